// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } lsu_state_t;

  // funct3 encodings (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  // op_data field positions
  localparam int OP_MEM_EN   = 10;
  localparam int OP_IS_STORE = 9;
  localparam int OP_F3_HI    = 8;
  localparam int OP_F3_LO    = 6;
  localparam int OP_RD_HI    = 4;
  localparam int OP_RD_LO    = 0;

  localparam int NUM_LANES = 4;

  // Context of the outstanding bus transaction
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ea;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } lsu_txn_t;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: f3_misaligned = off[0];
      F3_W:        f3_misaligned = (off != 2'b00);
      default:     f3_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store enables/replication and load lane select/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [NUM_LANES-1:0][7:0] rlane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign rlane = rdata;

  // Size from funct3[1:0]; lanes shifted by the address offset, data replicated
  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_f3[1:0])
      2'b00: begin
        be    = 4'(4'b0001 << st_off);
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        be    = 4'(4'b0011 << st_off);
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed lane(s) and sign/zero extend to 32 bits
  always_comb begin
    ld_byte = rlane[ld_off];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: effective address, single-outstanding req/ack bus,
// load write-back and exception reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_en,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] imm,
  input  logic [31:0] PC,
  input  logic [10:0] op_data,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_addr
);

  lsu_state_t  state;
  lsu_txn_t    txn;
  logic [15:0] tmo_cnt;

  logic [31:0] ea;
  logic [2:0]  f3;
  logic        is_store;
  logic        mem_en;
  logic [4:0]  rd;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        unused_op;

  assign ea        = r1 + imm;
  assign f3        = op_data[OP_F3_HI:OP_F3_LO];
  assign is_store  = op_data[OP_IS_STORE];
  assign mem_en    = op_data[OP_MEM_EN];
  assign rd        = op_data[OP_RD_HI:OP_RD_LO];
  assign unused_op = op_data[5];

  lsu_align u_align (
    .st_f3   (f3),
    .st_off  (ea[1:0]),
    .st_data (r2),
    .be      (st_be),
    .wdata   (st_wdata),
    .ld_f3   (txn.f3),
    .ld_off  (txn.ea[1:0]),
    .rdata   (mem_rdata),
    .ld_data (ld_data)
  );

  // Two-state FSM; every output is a register updated here
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      txn       <= '0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_cause <= EXC_NONE;
      exc_pc    <= '0;
      exc_addr  <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && mem_en) begin
            if (!f3_legal(f3, is_store)) begin
              exc_valid <= 1'b1;
              exc_cause <= EXC_ILLEGAL;
              exc_pc    <= PC;
              exc_addr  <= ea;
            end else if (f3_misaligned(f3, ea[1:0])) begin
              exc_valid <= 1'b1;
              exc_cause <= EXC_MISALIGN;
              exc_pc    <= PC;
              exc_addr  <= ea;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {ea[31:2], 2'b00};
              mem_be    <= st_be;
              mem_wdata <= is_store ? st_wdata : 32'd0;
              txn       <= '{pc: PC, ea: ea, rd: rd, f3: f3};
              tmo_cnt   <= '0;
              busy      <= 1'b1;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          // Ack beats the timeout when both land on the same edge
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
            if (!mem_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= txn.rd;
              wb_data  <= ld_data;
            end
          end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
            exc_valid <= 1'b1;
            exc_cause <= EXC_TIMEOUT;
            exc_pc    <= txn.pc;
            exc_addr  <= txn.ea;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: vector table for bus/exception cases, scoreboard for
// write-back and exception pulses, hand sequences for timeout and reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] r1 = '0, r2 = '0, imm = '0, PC = '0;
  logic [10:0] op_data = '0;
  logic        busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_pc, exc_addr;
  logic [1:0]  exc_cause;

  always #5 clk_en = ~clk_en;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk_en(clk_en), .rst(rst), .valid_in(valid_in),
    .r1(r1), .r2(r2), .imm(imm), .PC(PC), .op_data(op_data),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_addr(exc_addr)
  );

  typedef struct {
    logic        is_exc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic [31:0] r1, imm, r2;
    logic        st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic [1:0]  cause;  // 0 = bus transaction expected
    logic [31:0] addr;   // mem_addr, or exc_addr when cause != 0
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  localparam int NV = 18;
  vec_t tv[NV];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                       input logic [31:0] p, input logic st, input logic [2:0] f,
                       input logic [4:0] r);
    valid_in = 1'b1; r1 = a; imm = b; r2 = d; PC = p;
    op_data = {1'b1, st, f, 1'b0, r};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, busy, mem_req, mem_we, mem_be}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wb"}, {24'd0, wb_valid, wb_rd, exc_valid, exc_cause}, 32'd0);
    chk({tag, "_wbdata"}, wb_data, 32'd0);
    chk({tag, "_excpc"}, exc_pc, 32'd0);
    chk({tag, "_excaddr"}, exc_addr, 32'd0);
  endtask

  // Scoreboard: every wb/exc pulse must match the head of the queue
  always @(negedge clk_en) begin : mon
    exp_t e;
    if (wb_valid === 1'b1 || exc_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_pulse: got wb_valid=%b exc_valid=%b want none", wb_valid, exc_valid);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, wb_valid, exc_valid}, {30'd0, !e.is_exc, e.is_exc});
        if (e.is_exc) begin
          chk("exc_cause", {30'd0, exc_cause}, {30'd0, e.cause});
          chk("exc_pc", exc_pc, e.pc);
          chk("exc_addr", exc_addr, e.addr);
        end else begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] pc;
    //          r1            imm           r2            st    f3      rd     rdata         dly cause  addr          be     wdata         wb
    tv[0]  = '{32'h00001000, 32'h00000004, 32'h0,        1'b0, F3_W,  5'd5,  32'hDEADBEEF, 0, 2'b00, 32'h00001004, 4'hF, 32'h0,        32'hDEADBEEF};
    tv[1]  = '{32'h00001000, 32'h00000003, 32'h0,        1'b0, F3_B,  5'd6,  32'h80FFFFFF, 0, 2'b00, 32'h00001000, 4'h8, 32'h0,        32'hFFFFFF80};
    tv[2]  = '{32'h00001000, 32'h00000003, 32'h0,        1'b0, F3_BU, 5'd7,  32'h80FFFFFF, 0, 2'b00, 32'h00001000, 4'h8, 32'h0,        32'h00000080};
    tv[3]  = '{32'h00002000, 32'h00000002, 32'h0,        1'b0, F3_H,  5'd8,  32'h80011234, 2, 2'b00, 32'h00002000, 4'hC, 32'h0,        32'hFFFF8001};
    tv[4]  = '{32'h00002000, 32'h00000000, 32'h0,        1'b0, F3_HU, 5'd9,  32'h1234F00F, 1, 2'b00, 32'h00002000, 4'h3, 32'h0,        32'h0000F00F};
    tv[5]  = '{32'h00002000, 32'h00000001, 32'h0,        1'b0, F3_B,  5'd10, 32'h00007F00, 0, 2'b00, 32'h00002000, 4'h2, 32'h0,        32'h0000007F};
    tv[6]  = '{32'h00002000, 32'h00000002, 32'h1234ABCD, 1'b1, F3_H,  5'd0,  32'h0,        0, 2'b00, 32'h00002000, 4'hC, 32'hABCDABCD, 32'h0};
    tv[7]  = '{32'h00003000, 32'h00000001, 32'h000000A5, 1'b1, F3_B,  5'd0,  32'h0,        1, 2'b00, 32'h00003000, 4'h2, 32'hA5A5A5A5, 32'h0};
    tv[8]  = '{32'h00003010, 32'hFFFFFFF0, 32'hCAFEF00D, 1'b1, F3_W,  5'd0,  32'h0,        2, 2'b00, 32'h00003000, 4'hF, 32'hCAFEF00D, 32'h0};
    tv[9]  = '{32'h00001000, 32'h00000001, 32'h0,        1'b0, F3_W,  5'd1,  32'h0,        0, 2'b01, 32'h00001001, 4'h0, 32'h0,        32'h0};
    tv[10] = '{32'h00001000, 32'h00000000, 32'h0,        1'b0, 3'b011, 5'd1, 32'h0,        0, 2'b10, 32'h00001000, 4'h0, 32'h0,        32'h0};
    tv[11] = '{32'h00001000, 32'h00000008, 32'h0,        1'b1, F3_BU, 5'd0,  32'h0,        0, 2'b10, 32'h00001008, 4'h0, 32'h0,        32'h0};
    tv[12] = '{32'h00001000, 32'h00000003, 32'h0,        1'b0, F3_H,  5'd2,  32'h0,        0, 2'b01, 32'h00001003, 4'h0, 32'h0,        32'h0};
    tv[13] = '{32'hFFFFFFF0, 32'h0000000C, 32'h0,        1'b0, F3_W,  5'd0,  32'h11223344, 0, 2'b00, 32'hFFFFFFFC, 4'hF, 32'h0,        32'h11223344};
    tv[14] = '{32'hFFFFFFFF, 32'h00000005, 32'h0,        1'b0, F3_W,  5'd31, 32'h55AA55AA, 0, 2'b00, 32'h00000004, 4'hF, 32'h0,        32'h55AA55AA};
    tv[15] = '{32'h00002000, 32'h00000002, 32'h0,        1'b0, F3_HU, 5'd11, 32'h80011234, 0, 2'b00, 32'h00002000, 4'hC, 32'h0,        32'h00008001};
    tv[16] = '{32'h00003000, 32'h00000002, 32'h0,        1'b1, F3_W,  5'd0,  32'h0,        0, 2'b01, 32'h00003002, 4'h0, 32'h0,        32'h0};
    tv[17] = '{32'h00004000, 32'h00000007, 32'h0,        1'b0, 3'b111, 5'd3, 32'h0,        0, 2'b10, 32'h00004007, 4'h0, 32'h0,        32'h0};

    // Reset state
    repeat (2) @(negedge clk_en);
    chk_all_zero("reset");
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      pc = 32'h400 + 32'(i) * 4;
      @(negedge clk_en);
      drive(tv[i].r1, tv[i].imm, tv[i].r2, pc, tv[i].st, tv[i].f3, tv[i].rd);
      if (tv[i].cause != 2'b00)
        sb.push_back('{1'b1, 5'd0, 32'd0, tv[i].cause, pc, tv[i].addr});
      else if (!tv[i].st)
        sb.push_back('{1'b0, tv[i].rd, tv[i].wb, 2'b00, 32'd0, 32'd0});
      @(negedge clk_en);
      valid_in = 1'b0;
      if (tv[i].cause != 2'b00) begin
        chk("exc_no_req", {31'd0, mem_req}, 32'd0);
        chk("exc_no_busy", {31'd0, busy}, 32'd0);
      end else begin
        chk("req", {30'd0, mem_req, busy}, 32'd3);
        chk("we", {31'd0, mem_we}, {31'd0, tv[i].st});
        chk("addr", mem_addr, tv[i].addr);
        chk("be", {28'd0, mem_be}, {28'd0, tv[i].be});
        if (tv[i].st) chk("wdata", mem_wdata, tv[i].wdata);
        for (int k = 0; k < tv[i].dly; k++) begin
          // offered while busy: must be ignored (it would raise an exception)
          valid_in = 1'b1;
          op_data = {1'b1, 1'b0, 3'b011, 1'b0, 5'd1};
          @(negedge clk_en);
          valid_in = 1'b0;
          chk("hold_req", {31'd0, mem_req}, 32'd1);
          chk("hold_addr", mem_addr, tv[i].addr);
        end
        mem_ack = 1'b1;
        mem_rdata = tv[i].rdata;
        @(negedge clk_en);
        mem_ack = 1'b0;
        chk("done_idle", {30'd0, mem_req, busy}, 32'd0);
      end
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
    end

    // Non-memory op is ignored
    @(negedge clk_en);
    valid_in = 1'b1;
    op_data = {1'b0, 1'b0, 3'b011, 1'b0, 5'd4};
    @(negedge clk_en);
    valid_in = 1'b0;
    chk("nonmem_idle", {29'd0, mem_req, busy, exc_valid}, 32'd0);

    // Timeout: request held 4 cycles then cause 11
    @(negedge clk_en);
    drive(32'h5000, 32'h8, 32'h0, 32'h900, 1'b0, F3_W, 5'd3);
    sb.push_back('{1'b1, 5'd0, 32'd0, EXC_TIMEOUT, 32'h900, 32'h5008});
    @(negedge clk_en);
    valid_in = 1'b0;
    chk("tmo_req0", {31'd0, mem_req}, 32'd1);
    repeat (3) begin
      @(negedge clk_en);
      chk("tmo_req_held", {30'd0, mem_req, busy}, 32'd3);
    end
    @(negedge clk_en);
    chk("tmo_dropped", {30'd0, mem_req, busy}, 32'd0);
    #1;
    chk("tmo_drained", 32'(sb.size()), 32'd0);

    // Ack on the terminal-count edge completes normally
    @(negedge clk_en);
    drive(32'h5000, 32'h0, 32'h0, 32'h904, 1'b0, F3_W, 5'd4);
    sb.push_back('{1'b0, 5'd4, 32'h0BADF00D, 2'b00, 32'd0, 32'd0});
    @(negedge clk_en);
    valid_in = 1'b0;
    repeat (3) @(negedge clk_en);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(negedge clk_en);
    mem_ack = 1'b0;
    chk("lateack_idle", {30'd0, mem_req, busy}, 32'd0);
    #1;
    chk("lateack_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a bus transaction
    @(negedge clk_en);
    drive(32'h6000, 32'h0, 32'h0, 32'h908, 1'b0, F3_W, 5'd9);
    @(negedge clk_en);
    valid_in = 1'b0;
    chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1 chk_all_zero("midbus_rst");
    @(negedge clk_en);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h77777777;
    @(negedge clk_en);
    mem_ack = 1'b0;
    chk("post_rst_idle", {29'd0, mem_req, busy, wb_valid}, 32'd0);

    // Fresh load after reset
    @(negedge clk_en);
    drive(32'h7000, 32'h4, 32'h0, 32'h90C, 1'b0, F3_W, 5'd12);
    sb.push_back('{1'b0, 5'd12, 32'h01020304, 2'b00, 32'd0, 32'd0});
    @(negedge clk_en);
    valid_in = 1'b0;
    chk("fresh_addr", mem_addr, 32'h7004);
    mem_ack = 1'b1;
    mem_rdata = 32'h01020304;
    @(negedge clk_en);
    mem_ack = 1'b0;
    #1;
    chk("fresh_drained", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk_en);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
